// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer for the multicycle MIPS datapath: saves EPC/Cause,
// fetches the handler vector byte, loads PC, and restores PC on ERET. Optional macro: EXC_COUNT_EN.
module exception_sequencer #(
    parameter int VEC_ADDR    = 252,
    parameter int MEM_LATENCY = 1,
    parameter int PC_DEC      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        eret,
    input  logic [31:0] pc,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        busy,
    output logic        in_handler,
    output logic        halted,
`ifdef EXC_COUNT_EN
    output logic [7:0]  exc_count,
`endif
    output logic [2:0]  dbg_state
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAVE    = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_RESTORE = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;
    localparam logic [2:0] READ_LAST = 3'(MEM_LATENCY - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [7:0]  vec_q, vec_d;
    logic        inh_q, inh_d;
    logic        ovf_q, ovf_d;
    logic        accept, enter;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        vec_d   = vec_q;
        inh_d   = inh_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        enter   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Exceptions outrank ERET; opcode outranks overflow.
                if (exc_opcode || exc_overflow) begin
                    accept = 1'b1;
                    if (inh_q) begin
                        state_d = S_HALT;
                    end else begin
                        enter   = 1'b1;
                        ovf_d   = !exc_opcode;
                        state_d = S_SAVE;
                    end
                end else if (eret && inh_q) begin
                    accept  = 1'b1;
                    state_d = S_RESTORE;
                end
            end
            S_SAVE: begin
                epc_d   = pc - 32'(PC_DEC);
                cause_d = {31'b0, ovf_q};
                cnt_d   = 3'd0;
                state_d = S_READ;
            end
            S_READ: begin
                if (cnt_q == READ_LAST) begin
                    vec_d   = cause_q[0] ? mem_rdata[7:0] : mem_rdata[15:8];
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_LOAD: begin
                inh_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_RESTORE: begin
                inh_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
            vec_q   <= 8'd0;
            inh_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            vec_q   <= vec_d;
            inh_q   <= inh_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef EXC_COUNT_EN
    logic [7:0] count_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else if (enter && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end
    assign exc_count = count_q;
`else
    logic unused_enter;
    assign unused_enter = enter;
`endif

    // Outputs decode from state so an asynchronous reset clears them immediately.
    assign mem_req    = (state_q == S_READ);
    assign mem_addr   = mem_req ? 32'(VEC_ADDR) : 32'd0;
    assign pc_load    = (state_q == S_LOAD) || (state_q == S_RESTORE);
    assign pc_next    = (state_q == S_LOAD)    ? {24'b0, vec_q} :
                        (state_q == S_RESTORE) ? epc_q : 32'd0;
    assign busy       = (state_q != S_IDLE) || accept;
    assign halted     = (state_q == S_HALT);
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_handler = inh_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: entry, priority, ERET, double fault, reset mid-READ,
// and the EXC_COUNT_EN counter when that macro is defined.
module tb_exception_sequencer;
    logic        clock = 1'b0;
    logic        rst_n, rst3_n;
    logic        exc_opcode, exc_overflow, eret;
    logic [31:0] pc, mem_rdata;

    logic        mem_req, pc_load, busy, in_handler, halted;
    logic [31:0] mem_addr, epc, cause, pc_next;
    logic [2:0]  dbg_state;
    logic        mem_req3, pc_load3, busy3, in_handler3, halted3;
    logic [31:0] mem_addr3, epc3, cause3, pc_next3;
    logic [2:0]  dbg_state3;
`ifdef EXC_COUNT_EN
    logic [7:0]  exc_count, exc_count3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    exception_sequencer #(.VEC_ADDR(252), .MEM_LATENCY(1), .PC_DEC(4)) dut (
        .clock(clock), .reset(rst_n), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
        .eret(eret), .pc(pc), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .epc(epc), .cause(cause), .pc_next(pc_next), .pc_load(pc_load), .busy(busy),
        .in_handler(in_handler), .halted(halted),
`ifdef EXC_COUNT_EN
        .exc_count(exc_count),
`endif
        .dbg_state(dbg_state)
    );

    exception_sequencer #(.VEC_ADDR(252), .MEM_LATENCY(3), .PC_DEC(4)) dut3 (
        .clock(clock), .reset(rst3_n), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
        .eret(eret), .pc(pc), .mem_rdata(mem_rdata), .mem_req(mem_req3), .mem_addr(mem_addr3),
        .epc(epc3), .cause(cause3), .pc_next(pc_next3), .pc_load(pc_load3), .busy(busy3),
        .in_handler(in_handler3), .halted(halted3),
`ifdef EXC_COUNT_EN
        .exc_count(exc_count3),
`endif
        .dbg_state(dbg_state3)
    );

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        exc_opcode = 1'b0; exc_overflow = 1'b0; eret = 1'b0;
        pc = 32'd0; mem_rdata = 32'h0000FEFF;
        step(); step();
        n_cmp++;
        if ({mem_req, mem_addr, epc, cause, pc_next, pc_load, busy, in_handler, halted} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got epc=%h cause=%h pc_next=%h busy=%b, required all 0", epc, cause, pc_next, busy);
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_err++; $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        @(negedge clock); rst_n = 1'b1;
    endtask

    task automatic do_entry(input logic [31:0] p, input logic opc, input logic ovf,
                            input logic [31:0] exp_epc, input logic [31:0] exp_cause,
                            input logic [31:0] exp_pcn, input string nm);
        int busy_cnt = 0, req_cnt = 0, load_cnt = 0, load_at = -1;
        @(posedge clock); #1;
        pc = p; exc_opcode = opc; exc_overflow = ovf; #1;
        for (int c = 0; c < 8; c++) begin
            if (busy) busy_cnt++;
            if (mem_req) begin
                req_cnt++;
                n_cmp++;
                if (mem_addr !== 32'd252 || epc !== exp_epc || cause !== exp_cause) begin
                    n_err++;
                    $display("FAIL %s_read: got addr=%0d epc=%h cause=%h, required addr=252 epc=%h cause=%h",
                             nm, mem_addr, epc, cause, exp_epc, exp_cause);
                end
            end
            if (pc_load) begin
                load_cnt++;
                if (load_at < 0) load_at = c;
                n_cmp++;
                if (pc_next !== exp_pcn) begin
                    n_err++; $display("FAIL %s_pc_next: got %h, required %h", nm, pc_next, exp_pcn);
                end
            end
            @(posedge clock); #1;
            exc_opcode = 1'b0; exc_overflow = 1'b0; #1;
        end
        n_cmp++;
        if (busy_cnt !== 4 || req_cnt !== 1 || load_cnt !== 1 || load_at !== 3) begin
            n_err++;
            $display("FAIL %s_timing: got busy=%0d req=%0d loads=%0d load_at=%0d, required 4 1 1 3",
                     nm, busy_cnt, req_cnt, load_cnt, load_at);
        end
        n_cmp++;
        if (in_handler !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s_done: got in_handler=%b busy=%b, required 1 0", nm, in_handler, busy);
        end
    endtask

    task automatic test_eret(input logic [31:0] exp_pcn);
        @(posedge clock); #1;
        eret = 1'b1; #1;
        n_cmp++;
        if (busy !== 1'b1 || pc_load !== 1'b0) begin
            n_err++; $display("FAIL eret_accept: got busy=%b pc_load=%b, required 1 0", busy, pc_load);
        end
        @(posedge clock); #1; eret = 1'b0; #1;
        n_cmp++;
        if (pc_load !== 1'b1 || pc_next !== exp_pcn) begin
            n_err++; $display("FAIL eret_load: got pc_load=%b pc_next=%h, required 1 %h", pc_load, pc_next, exp_pcn);
        end
        step();
        n_cmp++;
        if (pc_load !== 1'b0 || in_handler !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL eret_done: got pc_load=%b in_handler=%b busy=%b, required 0 0 0", pc_load, in_handler, busy);
        end
    endtask

    task automatic test_eret_ignored();
        @(posedge clock); #1;
        eret = 1'b1; #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL eret_ign_busy: got %b, required 0", busy);
        end
        step();
        n_cmp++;
        if (pc_load !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_err++; $display("FAIL eret_ign_after: got pc_load=%b busy=%b state=%0d, required 0 0 0", pc_load, busy, dbg_state);
        end
        eret = 1'b0;
    endtask

    task automatic test_double_fault();
        @(posedge clock); #1;
        exc_overflow = 1'b1; pc = 32'h0000_0400; #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL dfault_accept: got busy=%b, required 1", busy);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 1) exc_overflow = 1'b0;
            n_cmp++;
            if (halted !== 1'b1 || busy !== 1'b1 || pc_load !== 1'b0 || mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL dfault_hold: got halted=%b busy=%b pc_load=%b mem_req=%b, required 1 1 0 0",
                         halted, busy, pc_load, mem_req);
            end
        end
        n_cmp++;
        if (epc !== 32'h0000_01FC || cause !== 32'd1) begin
            n_err++; $display("FAIL dfault_epc: got epc=%h cause=%h, required 000001fc 1", epc, cause);
        end
        #1 rst_n = 1'b0; #1;
        n_cmp++;
        if ({mem_req, mem_addr, epc, cause, pc_next, pc_load, busy, in_handler, halted, dbg_state} !== '0) begin
            n_err++; $display("FAIL dfault_reset: got halted=%b busy=%b state=%0d, required all 0", halted, busy, dbg_state);
        end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (halted !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_err++; $display("FAIL dfault_release: got halted=%b busy=%b state=%0d, required 0 0 0", halted, busy, dbg_state);
        end
    endtask

    task automatic test_reset_mid_read();
        int loads = 0;
        rst_n = 1'b0;
        rst3_n = 1'b1;
        @(posedge clock); #1;
        pc = 32'd0; exc_opcode = 1'b1; #1;
        n_cmp++;
        if (busy3 !== 1'b1) begin
            n_err++; $display("FAIL ml3_accept: got busy=%b, required 1", busy3);
        end
        @(posedge clock); #1; exc_opcode = 1'b0; #1;
        step();
        n_cmp++;
        if (mem_req3 !== 1'b1 || mem_addr3 !== 32'd252 || epc3 !== 32'hFFFF_FFFC || cause3 !== 32'd0) begin
            n_err++;
            $display("FAIL ml3_read: got req=%b addr=%0d epc=%h cause=%h, required 1 252 fffffffc 0",
                     mem_req3, mem_addr3, epc3, cause3);
        end
        step();
        n_cmp++;
        if (mem_req3 !== 1'b1 || pc_load3 !== 1'b0) begin
            n_err++; $display("FAIL ml3_read2: got req=%b pc_load=%b, required 1 0", mem_req3, pc_load3);
        end
        #1 rst3_n = 1'b0; #1;
        n_cmp++;
        if (mem_req3 !== 1'b0 || busy3 !== 1'b0 || epc3 !== 32'd0 || dbg_state3 !== 3'd0) begin
            n_err++;
            $display("FAIL ml3_async_reset: got req=%b busy=%b epc=%h state=%0d, required 0 0 0 0",
                     mem_req3, busy3, epc3, dbg_state3);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 1) rst3_n = 1'b1;
            if (pc_load3) loads++;
        end
        n_cmp++;
        if (loads !== 0 || in_handler3 !== 1'b0) begin
            n_err++; $display("FAIL ml3_no_load: got loads=%0d in_handler=%b, required 0 0", loads, in_handler3);
        end
        rst3_n = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

`ifdef EXC_COUNT_EN
    task automatic test_exc_count();
        n_cmp++;
        if (exc_count !== 8'd0) begin
            n_err++; $display("FAIL cnt_start: got %0d, required 0", exc_count);
        end
        for (int i = 0; i < 256; i++) begin
            @(posedge clock); #1; exc_opcode = 1'b1; pc = 32'h100;
            @(posedge clock); #1; exc_opcode = 1'b0;
            repeat (4) @(posedge clock);
            #1 eret = 1'b1;
            @(posedge clock); #1 eret = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            if (i == 0) begin
                n_cmp++;
                if (exc_count !== 8'd1) begin
                    n_err++; $display("FAIL cnt_first: got %0d, required 1", exc_count);
                end
            end
        end
        n_cmp++;
        if (exc_count !== 8'd255) begin
            n_err++; $display("FAIL cnt_saturate: got %0d, required 255", exc_count);
        end
        @(posedge clock); #1; exc_overflow = 1'b1;
        @(posedge clock); #1; exc_overflow = 1'b0;
        repeat (4) @(posedge clock);
        #1 exc_opcode = 1'b1;
        repeat (3) @(posedge clock);
        #1 exc_opcode = 1'b0;
        n_cmp++;
        if (halted !== 1'b1 || exc_count !== 8'd255) begin
            n_err++; $display("FAIL cnt_dfault: got halted=%b count=%0d, required 1 255", halted, exc_count);
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if (exc_count !== 8'd0) begin
            n_err++; $display("FAIL cnt_reset: got %0d, required 0", exc_count);
        end
        step();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        do_entry(32'h0000_0024, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'h0000_00FE, "opcode");
        test_eret(32'h0000_0020);
        test_eret_ignored();
        do_entry(32'h0000_1000, 1'b1, 1'b1, 32'h0000_0FFC, 32'd0, 32'h0000_00FE, "both");
        test_eret(32'h0000_0FFC);
        do_entry(32'h0000_0200, 1'b0, 1'b1, 32'h0000_01FC, 32'd1, 32'h0000_00FF, "overflow");
        test_double_fault();
        test_reset_mid_read();
`ifdef EXC_COUNT_EN
        test_exc_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Sequences exception entry and return for the multicycle MIPS datapath.
- On an invalid-opcode or overflow request it stalls the main control unit and saves EPC (faulting PC) and Cause.
- It then fetches the handler byte vector from the shared memory and loads it into PC.
- On ERET it restores PC from EPC. It is the sole owner of the EPC/Cause registers and of the vector-address memory slot.

Parameters:
- VEC_ADDR, 252, word address holding handler vectors: byte [15:8] = opcode handler, byte [7:0] = overflow handler.
- MEM_LATENCY, 1, cycles mem_req is held before mem_rdata is valid (1..4).
- PC_DEC, 4, amount subtracted from pc to form EPC.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- exc_opcode  in  1  invalid opcode detected, level, sampled in IDLE.
- exc_overflow  in  1  ALU overflow on a trapping op, level, sampled in IDLE.
- eret  in  1  return-from-exception request, sampled in IDLE.
- pc  in  32  current PC (already pc+4 of the faulting instruction).
- mem_rdata  in  32  memory read data.
- mem_req  out  1  sequencer owns memory address mux (read only, never writes).
- mem_addr  out  32  VEC_ADDR while mem_req=1, else 0.
- epc  out  32  exception PC register.
- cause  out  32  cause register: 0 = opcode, 1 = overflow.
- pc_next  out  32  value to load into PC.
- pc_load  out  1  one-cycle PC write strobe.
- busy  out  1  main control must hold its state while 1.
- in_handler  out  1  set after vector load, cleared by ERET.
- halted  out  1  double fault, sticky until reset.

Behaviour:
- Reset (reset=0, async): state IDLE. epc, cause, pc_next, mem_addr = 0. mem_req, pc_load, busy, in_handler, halted = 0.
- States: IDLE, SAVE, READ, LOAD, RESTORE, HALT.
- IDLE transitions:
  - Any exception with in_handler=0 -> SAVE. Priority: exc_opcode over exc_overflow when both are high.
  - Any exception with in_handler=1 -> HALT (double fault).
  - eret with in_handler=1 and no exception -> RESTORE. Exception beats eret if simultaneous.
  - eret with in_handler=0 is ignored.
- busy is combinationally 1 in every state except IDLE, and also in IDLE in the cycle a request is accepted, so main control stalls with zero delay.
- SAVE (1 cycle): epc <= pc - PC_DEC, mod 2^32 (pc=0 wraps to 0xFFFFFFFC). cause <= 0 (opcode) or 1 (overflow), zero-extended.
- READ (MEM_LATENCY cycles, internal counter):
  - mem_req=1, mem_addr=VEC_ADDR.
  - At the end of the final cycle, capture vector byte: cause=0 -> mem_rdata[15:8], cause=1 -> mem_rdata[7:0].
- LOAD (1 cycle): pc_next = {24'b0, byte}, pc_load=1. in_handler <= 1 at the end of the cycle. Next state IDLE.
- Entry latency: request accepted at edge T; pc_load high in cycle T+2+MEM_LATENCY; total busy cycles = 3+MEM_LATENCY counting the accept cycle.
- RESTORE (1 cycle): pc_next = epc, pc_load=1, in_handler <= 0. Next state IDLE. epc and cause are retained.
- HALT: busy=1, halted=1, mem_req=0, pc_load=0. Only reset exits.
- Requests arriving in SAVE/READ/LOAD/RESTORE are ignored; levels still high on return to IDLE are re-sampled.
- Reset mid-sequence: immediate return to IDLE with all outputs at reset values; no partial pc_load.
- pc_load is never high in two consecutive cycles.

Optional Feature:
- Macro EXC_COUNT_EN.
- Defined: adds output exc_count[7:0].
  - Reset 0.
  - Increments (saturating at 255) on each accepted entry into SAVE.
  - A double fault does not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Opcode exception, MEM_LATENCY=1: pc=0x00000024, exc_opcode=1, mem_rdata=0x0000FEFF -> epc=0x00000020, cause=0, mem_req high 1 cycle with mem_addr=252, pc_next=0x000000FE with pc_load pulse at accept+3, in_handler=1, busy high 4 cycles.
- Simultaneous exc_opcode=1 and exc_overflow=1, mem_rdata=0x0000FEFF -> cause=0, pc_next=0xFE. Overflow only -> cause=1, pc_next=0xFF.
- ERET after entry with epc=0x20 -> pc_next=0x00000020, one-cycle pc_load, in_handler=0. ERET with in_handler=0 -> no pc_load, busy stays 0.
- Second exception while in_handler=1 -> halted=1 and busy=1 until reset; reset=0 then 1 -> all outputs 0, state IDLE.
- Reset asserted during READ with MEM_LATENCY=3 -> mem_req drops asynchronously, no pc_load ever. pc=0 exception -> epc=0xFFFFFFFC.
- EXC_COUNT_EN: 256 entry/ERET pairs -> exc_count saturates at 255. A double fault leaves the count unchanged.
